// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between instruction fetch and data load/store
module unified_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int MEM_LAT = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_funct3,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, ERR} state_t;
  localparam logic [2:0] LAT = 3'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  state_t state;
  logic [2:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic if_win, dm_win, miss;
  always_comb begin
    if_win = if_req & (~dm_req | starve_cnt == SMAX);
    dm_win = dm_req & ~if_win;
    miss = if_win ? if_addr[1:0] != 2'b00
                  : (dm_funct3[1:0] == 2'b10 & dm_addr[1:0] != 2'b00) | (dm_funct3[1:0] == 2'b01 & dm_addr[0]);
  end
  assign stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lat_cnt <= '0;
      starve_cnt <= '0;
      if_gnt <= 1'b0;
      dm_gnt <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      err <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_funct3 <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt <= 1'b0;
      dm_gnt <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          // dm only beats a waiting fetch while starve_cnt < SMAX, so the increment saturates by itself
          starve_cnt <= (if_req & dm_win) ? starve_cnt + 4'd1 : 4'd0;
          if (if_win | dm_win) begin
            if (miss) begin
              state <= ERR;
              if_valid <= if_win;
              dm_valid <= dm_win;
              err <= 1'b1;
            end else begin
              state <= if_win ? BUSY_IF : BUSY_DM;
              if_gnt <= if_win;
              dm_gnt <= dm_win;
              mem_en <= 1'b1;
              mem_we <= dm_win & dm_we;
              mem_funct3 <= if_win ? 3'b010 : dm_funct3;
              mem_addr <= if_win ? if_addr : dm_addr;
              mem_wdata <= dm_win ? dm_wdata : mem_wdata;
              lat_cnt <= LAT;
            end
          end
        end
        ERR: state <= IDLE;
        default: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            state <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (state == BUSY_IF) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              dm_valid <= 1'b1;
              dm_rdata <= mem_we ? dm_rdata : mem_rdata;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: vector table, directed corner sequences and a random run against a cycle-schedule model
module tb_unified_mem_arbiter;
  localparam int LAT = 3;
  localparam int SMAX = 4;
  typedef struct {
    bit fetch;
    bit we;
    logic [2:0] f3;
    logic [7:0] addr;
    logic [31:0] wd;
    bit err;
    logic [31:0] rd;
  } vec_t;
  logic clk = 1'b0, rst;
  logic if_req, if_gnt, if_valid, dm_req, dm_we, dm_gnt, dm_valid, err, mem_en, mem_we, stall;
  logic [7:0] if_addr, dm_addr, mem_addr;
  logic [2:0] dm_funct3, mem_funct3;
  logic [31:0] if_rdata, dm_rdata, dm_wdata, mem_wdata, mem_rdata;
  int n_chk = 0, n_fail = 0;
  bit ram_init = 1'b1;
  logic [31:0] ram [64];
  logic [31:0] ref_mem [64];

  unified_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'h00500093 : (32'hC0DE0000 | 32'(i));
  endfunction

  // word-wide memory macro: data present whenever the address is held
  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk)
    if (ram_init) for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
    else if (mem_en && mem_we) ram[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_row(input vec_t v, input string nm);
    int gc, vc, en_n, we_n;
    bit e, bad;
    gc = -1; vc = -1; en_n = 0; we_n = 0; e = 1'b0; bad = 1'b0;
    if (v.fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      dm_req = 1'b1; dm_we = v.we; dm_funct3 = v.f3; dm_addr = v.addr; dm_wdata = v.wd;
    end
    #1 chk({nm, " stall0"}, stall, 1);
    for (int c = 1; c <= LAT + 4 && vc < 0; c++) begin
      tick();
      if (v.fetch ? if_gnt : dm_gnt) gc = c;
      if (v.fetch ? (dm_gnt | dm_valid) : (if_gnt | if_valid)) bad = 1'b1;
      if (mem_en) begin
        en_n++;
        if (mem_addr !== v.addr || mem_funct3 !== (v.fetch ? 3'b010 : v.f3) || mem_we !== (!v.fetch && v.we))
          bad = 1'b1;
      end
      if (mem_we) begin
        we_n++;
        if (mem_wdata !== v.wd) bad = 1'b1;
      end
      if (v.fetch ? if_valid : dm_valid) begin
        vc = c; e = err; if_req = 1'b0; dm_req = 1'b0;
      end else if (err) bad = 1'b1;
      #1 chk({nm, " stall"}, stall, vc < 0);
    end
    chk({nm, " gnt_cycle"}, gc, v.err ? -1 : 1);
    chk({nm, " valid_cycle"}, vc, v.err ? 1 : LAT + 1);
    chk({nm, " err"}, e, v.err);
    chk({nm, " en_cycles"}, en_n, v.err ? 0 : LAT);
    chk({nm, " we_cycles"}, we_n, (!v.fetch && v.we && !v.err) ? LAT : 0);
    chk({nm, " rdata"}, v.fetch ? if_rdata : dm_rdata, v.rd);
    chk({nm, " protocol"}, bad, 0);
    tick();
  endtask

  task automatic both_req();
    int ig = -1, iv = -1, dg = -1, dv = -1;
    if_req = 1'b1; if_addr = 8'h08;
    dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = 3'b010; dm_addr = 8'h10;
    for (int c = 1; c <= 2 * LAT + 8 && iv < 0; c++) begin
      tick();
      if (if_gnt && ig < 0) ig = c;
      if (dm_gnt && dg < 0) dg = c;
      if (dm_valid) begin dv = c; dm_req = 1'b0; end
      if (if_valid) begin iv = c; if_req = 1'b0; end
    end
    chk("both dm_gnt", dg, 1);
    chk("both dm_valid", dv, LAT + 1);
    chk("both if_gnt", ig, LAT + 2);
    chk("both if_valid", iv, 2 * LAT + 2);
    chk("both dm_rdata", dm_rdata, 32'hC0DE0004);
    chk("both if_rdata", if_rdata, 32'h00500093);
    tick();
  endtask

  task automatic starve_seq();
    int ng = 0;
    logic [9:0] ord = '0;
    bit both = 1'b0;
    if_req = 1'b1; if_addr = 8'h0C;
    dm_req = 1'b1; dm_we = 1'b1; dm_funct3 = 3'b010; dm_addr = 8'h44; dm_wdata = 32'h11111111;
    for (int c = 0; c < 200 && ng < 10; c++) begin
      tick();
      if (if_gnt && dm_gnt) both = 1'b1;
      if (if_gnt || dm_gnt) begin ord[ng] = if_gnt; ng++; end
    end
    chk("starve grants", ng, 10);
    chk("starve order", ord, 10'b1000010000);
    chk("starve dual gnt", both, 0);
    for (int c = 0; c < LAT + 4 && !if_valid; c++) tick();
    chk("starve last valid", if_valid, 1);
    if_req = 1'b0; dm_req = 1'b0;
    tick();
  endtask

  task automatic reset_mid();
    bit seen = 1'b0;
    vec_t f = '{1'b1, 1'b0, 3'b010, 8'h08, 32'h0, 1'b0, 32'h00500093};
    dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = 3'b000; dm_addr = 8'h13;
    tick();
    chk("rst dm_gnt", dm_gnt, 1);
    chk("rst busy1 en", mem_en, 1);
    tick();
    chk("rst busy2 en", mem_en, 1);
    rst = 1'b1; dm_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst en dropped", mem_en, 0);
    for (int c = 0; c < LAT + 3; c++) begin
      if (dm_valid || err || mem_en) seen = 1'b1;
      tick();
    end
    chk("rst no completion", seen, 0);
    chk("rst dm_rdata", dm_rdata, 0);
    run_row(f, "rst fetch");
  endtask

  task automatic rand_phase();
    logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bit act = 1'b0, t_if = 1'b0, t_err = 1'b0, t_we = 1'b0;
    int t_gnt = 0, t_val = 0, free_at = 0, lost = 0;
    logic [2:0] t_f3 = '0;
    logic [7:0] t_addr = '0;
    logic [31:0] t_wd = '0, e_ird = '0, e_drd = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = ram[i];
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit e_ig, e_dg, e_iv, e_dv, e_er, e_en, w_if;
      tick();
      e_ig = act && t_if && !t_err && cyc == t_gnt;
      e_dg = act && !t_if && !t_err && cyc == t_gnt;
      e_iv = act && t_if && cyc == t_val;
      e_dv = act && !t_if && cyc == t_val;
      e_er = act && t_err && cyc == t_val;
      e_en = act && !t_err && cyc >= t_gnt && cyc < t_val;
      if (act && cyc == t_val && !t_err && !t_we) begin
        if (t_if) e_ird = ref_mem[t_addr[7:2]];
        else e_drd = ref_mem[t_addr[7:2]];
      end
      chk("rnd if_gnt", if_gnt, e_ig);
      chk("rnd dm_gnt", dm_gnt, e_dg);
      chk("rnd if_valid", if_valid, e_iv);
      chk("rnd dm_valid", dm_valid, e_dv);
      chk("rnd err", err, e_er);
      chk("rnd mem_en", mem_en, e_en);
      chk("rnd if_rdata", if_rdata, e_ird);
      chk("rnd dm_rdata", dm_rdata, e_drd);
      if (e_en) begin
        chk("rnd mem_addr", mem_addr, t_addr);
        chk("rnd mem_we", mem_we, t_we);
        chk("rnd mem_funct3", mem_funct3, t_f3);
        if (t_we) chk("rnd mem_wdata", mem_wdata, t_wd);
      end
      if (act && cyc == t_val) act = 1'b0;
      if (e_iv || !if_req) begin
        if_req = $urandom_range(0, 2) != 0;
        if_addr = 8'($urandom) & (($urandom_range(0, 5) == 0) ? 8'hFF : 8'hFC);
      end
      if (e_dv || !dm_req) begin
        dm_req = $urandom_range(0, 2) != 0;
        dm_we = $urandom_range(0, 2) == 0;
        dm_funct3 = dm_we ? 3'($urandom_range(0, 2)) : f3s[$urandom_range(0, 4)];
        dm_addr = 8'($urandom) & (($urandom_range(0, 3) == 0) ? 8'hFF : 8'hFC);
        dm_wdata = $urandom;
      end
      if (cyc >= free_at) begin
        if (if_req || dm_req) begin
          w_if = if_req && (!dm_req || lost == SMAX);
          lost = (if_req && !w_if) ? ((lost < SMAX) ? lost + 1 : SMAX) : 0;
          act = 1'b1;
          t_if = w_if;
          t_addr = w_if ? if_addr : dm_addr;
          t_we = !w_if && dm_we;
          t_f3 = w_if ? 3'b010 : dm_funct3;
          t_wd = dm_wdata;
          t_err = (t_f3[1:0] == 2'b10 && t_addr[1:0] != 2'b00) || (t_f3[1:0] == 2'b01 && t_addr[0]);
          t_gnt = cyc + 1;
          t_val = t_err ? cyc + 1 : cyc + 1 + LAT;
          free_at = t_err ? cyc + 2 : t_val;
          if (t_we && !t_err) ref_mem[t_addr[7:2]] = t_wd;
        end else lost = 0;
      end
      #1 chk("rnd stall", stall, (if_req && !e_iv) || (dm_req && !e_dv));
    end
    if_req = 1'b0; dm_req = 1'b0;
    for (int c = 0; c < LAT + 3; c++) tick();
  endtask

  initial begin
    vec_t tbl [13];
    tbl[0]  = '{1'b1, 1'b0, 3'b010, 8'h08, 32'h0, 1'b0, 32'h00500093};
    tbl[1]  = '{1'b0, 1'b0, 3'b010, 8'h10, 32'h0, 1'b0, 32'hC0DE0004};
    tbl[2]  = '{1'b0, 1'b1, 3'b001, 8'h21, 32'h12345678, 1'b1, 32'hC0DE0004};
    tbl[3]  = '{1'b0, 1'b1, 3'b010, 8'h40, 32'hDEADBEEF, 1'b0, 32'hC0DE0004};
    tbl[4]  = '{1'b0, 1'b0, 3'b010, 8'h40, 32'h0, 1'b0, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 1'b0, 3'b000, 8'h13, 32'h0, 1'b0, 32'hC0DE0004};
    tbl[6]  = '{1'b0, 1'b0, 3'b101, 8'h22, 32'h0, 1'b0, 32'hC0DE0008};
    tbl[7]  = '{1'b0, 1'b0, 3'b001, 8'h23, 32'h0, 1'b1, 32'hC0DE0008};
    tbl[8]  = '{1'b0, 1'b0, 3'b010, 8'h12, 32'h0, 1'b1, 32'hC0DE0008};
    tbl[9]  = '{1'b1, 1'b0, 3'b010, 8'h06, 32'h0, 1'b1, 32'h00500093};
    tbl[10] = '{1'b1, 1'b0, 3'b010, 8'h0C, 32'h0, 1'b0, 32'hC0DE0003};
    tbl[11] = '{1'b0, 1'b0, 3'b100, 8'h3F, 32'h0, 1'b0, 32'hC0DE000F};
    tbl[12] = '{1'b0, 1'b1, 3'b000, 8'h41, 32'h000000AA, 1'b0, 32'hC0DE000F};
    if_addr = '0; dm_we = 1'b0; dm_funct3 = '0; dm_addr = '0; dm_wdata = '0;
    do_reset();
    ram_init = 1'b0;
    chk("reset if_gnt", if_gnt, 0);
    chk("reset dm_gnt", dm_gnt, 0);
    chk("reset if_valid", if_valid, 0);
    chk("reset dm_valid", dm_valid, 0);
    chk("reset err", err, 0);
    chk("reset mem_en", mem_en, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_funct3", mem_funct3, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset if_rdata", if_rdata, 0);
    chk("reset dm_rdata", dm_rdata, 0);
    chk("reset stall", stall, 0);
    for (int i = 0; i < 13; i++) run_row(tbl[i], $sformatf("row%0d", i));
    both_req();
    starve_seq();
    reset_mid();
    do_reset();
    rand_phase();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port and the data load/store port of the single-cycle RISC-V core.
- Arbitrates between the two ports, sequences each access over MEM_LAT cycles and returns completion with a valid pulse.
- Asserts stall so the core holds PC and suppresses register write-back while an access is pending.
- Sits between the core (PC / ALU address path) and the unified memory macro.

Parameters:
- ADDR_W, 8, byte address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from mem_en assertion to mem_rdata valid (1..7).
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch gets forced priority (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with stable if_addr until if_valid.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  one-cycle pulse: fetch accepted.
- if_rdata  out  DATA_W  fetched instruction; valid when if_valid=1.
- if_valid  out  1  one-cycle pulse: fetch complete.
- dm_req  in  1  data request; held with stable command until dm_valid.
- dm_we  in  1  1 = store, 0 = load.
- dm_funct3  in  3  access size/sign (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
- dm_addr  in  ADDR_W  data byte address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  one-cycle pulse: data access accepted.
- dm_rdata  out  DATA_W  load data; valid when dm_valid=1.
- dm_valid  out  1  one-cycle pulse: data access complete.
- err  out  1  pulses with x_valid when the access was misaligned and not issued.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_funct3  out  3  size to memory; forced to 010 for fetch.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- stall  out  1  (if_req & ~if_valid) | (dm_req & ~dm_valid); combinational.

Behaviour:
- All outputs are registered except stall.
- Reset:
  - state=IDLE, lat_cnt=0, starve_cnt=0.
  - All gnt/valid/err/mem_* outputs are 0; rdata registers are 0.
- FSM states: IDLE, BUSY_IF, BUSY_DM, ERR.
- Arbitration happens only in IDLE, on the requests sampled that cycle:
  - Only one request → it wins.
  - Both requesting → dm wins, unless starve_cnt==STARVE_MAX, in which case if wins.
- Alignment check (IDLE):
  - Misaligned: lw/if with addr[1:0]≠0, or lh/lhu with addr[0]≠0.
  - A misaligned winner → ERR. Next cycle: that port's valid=1, err=1, rdata unchanged, mem_en stays 0; then → IDLE.
- Issue (aligned winner, on the next edge):
  - Latch addr/we/funct3/wdata into the command register.
  - Pulse that port's gnt; drive mem_en=1 and mem_* from the command register.
  - lat_cnt=MEM_LAT; enter BUSY_x.
- BUSY_x:
  - mem_* held constant; lat_cnt decrements each cycle.
  - At lat_cnt==1: capture mem_rdata into x_rdata (loads and fetch only), go to IDLE, pulse x_valid.
  - mem_en/mem_we drop to 0 in the same edge.
- Stores: memory samples mem_wdata while mem_we=1. dm_valid signals completion; dm_rdata is unchanged.
- Latency: x_valid rises MEM_LAT+1 cycles after the edge that samples x_req in IDLE.
  - The valid cycle is an IDLE cycle.
  - Peak throughput is one access per MEM_LAT+1 cycles.
- Back-to-back: a req still high in the cycle its valid is high counts as a new request. The requester must drop req in that cycle for a single access.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_MAX) on each IDLE arbitration where if_req=1 and dm wins.
  - It clears when fetch is granted or when if_req=0 in IDLE.
- Simultaneous events:
  - Requests arriving while BUSY are not sampled until IDLE. The port not being served is not dropped.
  - gnt and valid of different ports never coincide with each other in the same cycle.
- Reset mid-operation:
  - The transaction is abandoned: no valid/err pulse.
  - mem_en=0 from the cycle after the reset edge; the FSM goes to IDLE.
- Requester changing command while pending: undefined for the requester. The arbiter uses only the latched command.

Test Plan:
- Reset, then if_req=1, if_addr=0x08, MEM_LAT=1, mem_rdata=0x00500093:
  - if_gnt at cycle 1; mem_en=1, mem_addr=0x08, mem_funct3=010 at cycle 1.
  - if_valid=1, if_rdata=0x00500093 at cycle 2; stall=1 cycles 0–1, 0 at cycle 2.
- if_req and dm_req (load lw 0x10) both high in the same IDLE cycle:
  - dm_gnt first; dm_valid at +2; if_gnt in the following cycle; if_valid 2 cycles later.
  - With MEM_LAT=3 the sequence is identical with 4-cycle gaps.
- dm_req held continuously (back-to-back stores) with if_req=1, STARVE_MAX=4:
  - Four dm grants, then the fifth arbitration grants fetch; starve_cnt returns to 0 after the fetch grant.
- Store sh to 0x21:
  - No mem_en ever; next cycle dm_valid=1 and err=1; state back to IDLE; dm_rdata unchanged.
- MEM_LAT=3, lb at 0x13, rst asserted at the second BUSY cycle:
  - mem_en=0 the cycle after; no dm_valid; a subsequent if_req is served normally with latency 4.
- Store sw 0x40 data 0xDEADBEEF:
  - mem_we=1, mem_wdata=0xDEADBEEF for exactly MEM_LAT cycles; dm_valid pulses once.
  - dm_rdata keeps its previous value; err=0.
